// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Drives TLB write/read/invtlb ports from CSRs and shares search port 1 with
// load/store translation. Ports: i_op_* request, o_srch_*/o_rd_*/o_inv_err
// results with o_op_done, i_mem_*/o_mem_stall lookup sharing, o_tlb_*/i_tlb_*
// to/from the tlb instance.
module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_op_valid,
    input  logic [2:0]       i_op_code,
    output logic             o_op_ready,
    input  logic [4:0]       i_inv_op,
    input  logic [9:0]       i_inv_asid,
    input  logic [18:0]      i_inv_vppn,
    input  logic [31:0]      i_csr_tlbidx,
    input  logic [31:0]      i_csr_tlbehi,
    input  logic [31:0]      i_csr_tlbelo0,
    input  logic [31:0]      i_csr_tlbelo1,
    input  logic [31:0]      i_csr_asid,
    output logic             o_op_done,
    output logic             o_srch_found,
    output logic [IDX_W-1:0] o_srch_index,
    output logic [31:0]      o_rd_tlbidx,
    output logic [31:0]      o_rd_tlbehi,
    output logic [31:0]      o_rd_tlbelo0,
    output logic [31:0]      o_rd_tlbelo1,
    output logic [31:0]      o_rd_asid,
    output logic             o_inv_err,
    input  logic [18:0]      i_mem_vppn,
    input  logic             i_mem_va_bit12,
    input  logic [9:0]       i_mem_asid,
    output logic             o_mem_stall,
    output logic [18:0]      o_tlb_s1_vppn,
    output logic             o_tlb_s1_va_bit12,
    output logic [9:0]       o_tlb_s1_asid,
    input  logic             i_tlb_s1_found,
    input  logic [IDX_W-1:0] i_tlb_s1_index,
    output logic             o_tlb_we,
    output logic [IDX_W-1:0] o_tlb_w_index,
    output logic             o_tlb_w_e,
    output logic [5:0]       o_tlb_w_ps,
    output logic [18:0]      o_tlb_w_vppn,
    output logic [9:0]       o_tlb_w_asid,
    output logic             o_tlb_w_g,
    output logic [19:0]      o_tlb_w_ppn0,
    output logic [1:0]       o_tlb_w_mat0,
    output logic [1:0]       o_tlb_w_plv0,
    output logic             o_tlb_w_d0,
    output logic             o_tlb_w_v0,
    output logic [19:0]      o_tlb_w_ppn1,
    output logic [1:0]       o_tlb_w_mat1,
    output logic [1:0]       o_tlb_w_plv1,
    output logic             o_tlb_w_d1,
    output logic             o_tlb_w_v1,
    output logic [IDX_W-1:0] o_tlb_r_index,
    input  logic             i_tlb_r_e,
    input  logic [5:0]       i_tlb_r_ps,
    input  logic [18:0]      i_tlb_r_vppn,
    input  logic [9:0]       i_tlb_r_asid,
    input  logic             i_tlb_r_g,
    input  logic [19:0]      i_tlb_r_ppn0,
    input  logic [1:0]       i_tlb_r_mat0,
    input  logic [1:0]       i_tlb_r_plv0,
    input  logic             i_tlb_r_d0,
    input  logic             i_tlb_r_v0,
    input  logic [19:0]      i_tlb_r_ppn1,
    input  logic [1:0]       i_tlb_r_mat1,
    input  logic [1:0]       i_tlb_r_plv1,
    input  logic             i_tlb_r_d1,
    input  logic             i_tlb_r_v1,
    output logic             o_tlb_invtlb_valid,
    output logic [4:0]       o_tlb_invtlb_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH,
        S_RD,
        S_WRITE,
        S_INV,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op_code;
    logic [4:0]       r_inv_op;
    logic [9:0]       r_inv_asid;
    logic [18:0]      r_inv_vppn;
    logic [IDX_W-1:0] r_fill_cnt;
    logic [IDX_W-1:0] r_fill_idx;
    logic             r_srch_found;
    logic [IDX_W-1:0] r_srch_index;
    logic [31:0]      r_rd_tlbidx;
    logic [31:0]      r_rd_tlbehi;
    logic [31:0]      r_rd_tlbelo0;
    logic [31:0]      r_rd_tlbelo1;
    logic [31:0]      r_rd_asid;
    logic             r_inv_err;

    logic             w_accept;
    logic [IDX_W-1:0] w_csr_idx;
    logic             w_inv_ok;

    assign w_accept  = i_op_valid && (r_state == S_IDLE);
    assign w_csr_idx = i_csr_tlbidx[IDX_W-1:0];
    assign w_inv_ok  = (r_inv_op <= 5'd6);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_op_valid) begin
                    unique case (i_op_code)
                        OP_SRCH: w_next = S_SRCH;
                        OP_RD:   w_next = S_RD;
                        OP_WR:   w_next = S_WRITE;
                        OP_FILL: w_next = S_WRITE;
                        OP_INV:  w_next = S_INV;
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_SRCH:  w_next = S_DONE;
            S_RD:    w_next = S_DONE;
            S_WRITE: w_next = S_DONE;
            S_INV:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Free-running fill pointer; the accept-cycle value picks the FILL slot.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fill_cnt <= '0;
        end else if (r_fill_cnt == IDX_W'(TLBNUM - 1)) begin
            r_fill_cnt <= '0;
        end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op_code  <= '0;
            r_inv_op   <= '0;
            r_inv_asid <= '0;
            r_inv_vppn <= '0;
            r_fill_idx <= '0;
        end else if (w_accept) begin
            r_op_code  <= i_op_code;
            r_inv_op   <= i_inv_op;
            r_inv_asid <= i_inv_asid;
            r_inv_vppn <= i_inv_vppn;
            r_fill_idx <= r_fill_cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_srch_found <= 1'b0;
            r_srch_index <= '0;
            r_rd_tlbidx  <= '0;
            r_rd_tlbehi  <= '0;
            r_rd_tlbelo0 <= '0;
            r_rd_tlbelo1 <= '0;
            r_rd_asid    <= '0;
            r_inv_err    <= 1'b0;
        end else begin
            if (r_state == S_SRCH) begin
                r_srch_found <= i_tlb_s1_found;
                r_srch_index <= i_tlb_s1_index;
            end
            if (r_state == S_RD) begin
                if (i_tlb_r_e) begin
                    r_rd_tlbidx  <= {2'b00, i_tlb_r_ps,
                                     {(24 - IDX_W){1'b0}}, w_csr_idx};
                    r_rd_tlbehi  <= {i_tlb_r_vppn, 13'b0};
                    r_rd_tlbelo0 <= {4'b0, i_tlb_r_ppn0, 1'b0, i_tlb_r_g,
                                     i_tlb_r_mat0, i_tlb_r_plv0,
                                     i_tlb_r_d0, i_tlb_r_v0};
                    r_rd_tlbelo1 <= {4'b0, i_tlb_r_ppn1, 1'b0, i_tlb_r_g,
                                     i_tlb_r_mat1, i_tlb_r_plv1,
                                     i_tlb_r_d1, i_tlb_r_v1};
                    r_rd_asid    <= {22'b0, i_tlb_r_asid};
                end else begin
                    // Empty entry: NE set, only the index is reported.
                    r_rd_tlbidx  <= {1'b1, {(31 - IDX_W){1'b0}}, w_csr_idx};
                    r_rd_tlbehi  <= '0;
                    r_rd_tlbelo0 <= '0;
                    r_rd_tlbelo1 <= '0;
                    r_rd_asid    <= '0;
                end
            end
            if (r_state == S_INV) begin
                r_inv_err <= ~w_inv_ok;
            end
        end
    end

    // Search port 1 belongs to the controller only in SRCH and INV.
    always_comb begin
        o_tlb_s1_vppn     = i_mem_vppn;
        o_tlb_s1_va_bit12 = i_mem_va_bit12;
        o_tlb_s1_asid     = i_mem_asid;
        if (r_state == S_SRCH) begin
            o_tlb_s1_vppn     = i_csr_tlbehi[31:13];
            o_tlb_s1_va_bit12 = 1'b0;
            o_tlb_s1_asid     = i_csr_asid[9:0];
        end else if (r_state == S_INV) begin
            o_tlb_s1_vppn     = r_inv_vppn;
            o_tlb_s1_va_bit12 = 1'b0;
            o_tlb_s1_asid     = r_inv_asid;
        end
    end

    assign o_mem_stall = (r_state == S_SRCH) || (r_state == S_INV);
    assign o_op_ready  = (r_state == S_IDLE);
    assign o_op_done   = (r_state == S_DONE);

    assign o_tlb_we      = (r_state == S_WRITE);
    assign o_tlb_w_index = (r_op_code == OP_FILL) ? r_fill_idx : w_csr_idx;
    assign o_tlb_w_e     = ~i_csr_tlbidx[31];
    assign o_tlb_w_ps    = i_csr_tlbidx[29:24];
    assign o_tlb_w_vppn  = i_csr_tlbehi[31:13];
    assign o_tlb_w_asid  = i_csr_asid[9:0];
    assign o_tlb_w_g     = i_csr_tlbelo0[6] & i_csr_tlbelo1[6];
    assign o_tlb_w_ppn0  = i_csr_tlbelo0[27:8];
    assign o_tlb_w_mat0  = i_csr_tlbelo0[5:4];
    assign o_tlb_w_plv0  = i_csr_tlbelo0[3:2];
    assign o_tlb_w_d0    = i_csr_tlbelo0[1];
    assign o_tlb_w_v0    = i_csr_tlbelo0[0];
    assign o_tlb_w_ppn1  = i_csr_tlbelo1[27:8];
    assign o_tlb_w_mat1  = i_csr_tlbelo1[5:4];
    assign o_tlb_w_plv1  = i_csr_tlbelo1[3:2];
    assign o_tlb_w_d1    = i_csr_tlbelo1[1];
    assign o_tlb_w_v1    = i_csr_tlbelo1[0];

    assign o_tlb_r_index = w_csr_idx;

    assign o_tlb_invtlb_valid = (r_state == S_INV) && w_inv_ok;
    assign o_tlb_invtlb_op    = r_inv_op;

    assign o_srch_found = r_srch_found;
    assign o_srch_index = r_srch_index;
    assign o_rd_tlbidx  = r_rd_tlbidx;
    assign o_rd_tlbehi  = r_rd_tlbehi;
    assign o_rd_tlbelo0 = r_rd_tlbelo0;
    assign o_rd_tlbelo1 = r_rd_tlbelo1;
    assign o_rd_asid    = r_rd_asid;
    assign o_inv_err    = r_inv_err;

    // CSR bits that carry no TLB state.
    logic w_unused;
    assign w_unused = &{1'b0, i_csr_tlbidx[30], i_csr_tlbidx[23:IDX_W],
                        i_csr_tlbehi[12:0], i_csr_tlbelo0[31:28],
                        i_csr_tlbelo0[7], i_csr_tlbelo1[31:28],
                        i_csr_tlbelo1[7], i_csr_asid[31:10]};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed bench for tlb_op_ctrl with a small TLB model.
// Checks are immediate assertions at negedge sample points.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic        op_ready;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [18:0] inv_vppn = '0;
    logic [31:0] csr_tlbidx = '0, csr_tlbehi = '0;
    logic [31:0] csr_tlbelo0 = '0, csr_tlbelo1 = '0, csr_asid = '0;
    logic        op_done, srch_found, inv_err;
    logic [3:0]  srch_index;
    logic [31:0] rd_tlbidx, rd_tlbehi, rd_tlbelo0, rd_tlbelo1, rd_asid;
    logic [18:0] mem_vppn = '0;
    logic        mem_va_bit12 = 1'b0;
    logic [9:0]  mem_asid = '0;
    logic        mem_stall;
    logic [18:0] s1_vppn;
    logic        s1_va_bit12;
    logic [9:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic        tlb_we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [3:0]  w_index, r_index;
    logic [5:0]  w_ps;
    logic [18:0] w_vppn;
    logic [9:0]  w_asid;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0]  w_mat0, w_plv0, w_mat1, w_plv1;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;

    typedef struct packed {
        logic        e;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  mat0, plv0;
        logic        d0, v0;
        logic [19:0] ppn1;
        logic [1:0]  mat1, plv1;
        logic        d1, v1;
    } ent_t;

    ent_t       m_tlb [16] = '{default: '0};
    ent_t       rd_ent;
    logic [3:0] m_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tlb_we) begin
            m_tlb[w_index] <= '{w_e, w_ps, w_vppn, w_asid, w_g,
                                w_ppn0, w_mat0, w_plv0, w_d0, w_v0,
                                w_ppn1, w_mat1, w_plv1, w_d1, w_v1};
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) m_cnt <= '0;
        else       m_cnt <= m_cnt + 4'd1;
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < 16; i++) begin
            if (!s1_found && m_tlb[i].e && m_tlb[i].vppn == s1_vppn &&
                (m_tlb[i].g || m_tlb[i].asid == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = 4'(i);
            end
        end
    end

    assign rd_ent = m_tlb[r_index];

    tlb_op_ctrl dut (
        .i_clk(clk), .i_reset(reset),
        .i_op_valid(op_valid), .i_op_code(op_code), .o_op_ready(op_ready),
        .i_inv_op(inv_op), .i_inv_asid(inv_asid), .i_inv_vppn(inv_vppn),
        .i_csr_tlbidx(csr_tlbidx), .i_csr_tlbehi(csr_tlbehi),
        .i_csr_tlbelo0(csr_tlbelo0), .i_csr_tlbelo1(csr_tlbelo1),
        .i_csr_asid(csr_asid),
        .o_op_done(op_done), .o_srch_found(srch_found),
        .o_srch_index(srch_index),
        .o_rd_tlbidx(rd_tlbidx), .o_rd_tlbehi(rd_tlbehi),
        .o_rd_tlbelo0(rd_tlbelo0), .o_rd_tlbelo1(rd_tlbelo1),
        .o_rd_asid(rd_asid), .o_inv_err(inv_err),
        .i_mem_vppn(mem_vppn), .i_mem_va_bit12(mem_va_bit12),
        .i_mem_asid(mem_asid), .o_mem_stall(mem_stall),
        .o_tlb_s1_vppn(s1_vppn), .o_tlb_s1_va_bit12(s1_va_bit12),
        .o_tlb_s1_asid(s1_asid),
        .i_tlb_s1_found(s1_found), .i_tlb_s1_index(s1_index),
        .o_tlb_we(tlb_we), .o_tlb_w_index(w_index), .o_tlb_w_e(w_e),
        .o_tlb_w_ps(w_ps), .o_tlb_w_vppn(w_vppn), .o_tlb_w_asid(w_asid),
        .o_tlb_w_g(w_g),
        .o_tlb_w_ppn0(w_ppn0), .o_tlb_w_mat0(w_mat0), .o_tlb_w_plv0(w_plv0),
        .o_tlb_w_d0(w_d0), .o_tlb_w_v0(w_v0),
        .o_tlb_w_ppn1(w_ppn1), .o_tlb_w_mat1(w_mat1), .o_tlb_w_plv1(w_plv1),
        .o_tlb_w_d1(w_d1), .o_tlb_w_v1(w_v1),
        .o_tlb_r_index(r_index),
        .i_tlb_r_e(rd_ent.e), .i_tlb_r_ps(rd_ent.ps),
        .i_tlb_r_vppn(rd_ent.vppn), .i_tlb_r_asid(rd_ent.asid),
        .i_tlb_r_g(rd_ent.g),
        .i_tlb_r_ppn0(rd_ent.ppn0), .i_tlb_r_mat0(rd_ent.mat0),
        .i_tlb_r_plv0(rd_ent.plv0), .i_tlb_r_d0(rd_ent.d0),
        .i_tlb_r_v0(rd_ent.v0),
        .i_tlb_r_ppn1(rd_ent.ppn1), .i_tlb_r_mat1(rd_ent.mat1),
        .i_tlb_r_plv1(rd_ent.plv1), .i_tlb_r_d1(rd_ent.d1),
        .i_tlb_r_v1(rd_ent.v1),
        .o_tlb_invtlb_valid(invtlb_valid), .o_tlb_invtlb_op(invtlb_op)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the next negedge, issue op, return in the op-state cycle.
    task automatic issue(input logic [2:0] code);
        @(negedge clk);
        chk("ready_before_issue", op_ready, 1);
        op_valid = 1'b1;
        op_code  = code;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic to_done();
        @(negedge clk);
        chk("op_done", op_done, 1);
        chk("we_in_done", tlb_we, 0);
        chk("stall_in_done", mem_stall, 0);
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        for (int i = 0; i < 40 && m_cnt != v; i++) @(negedge clk);
        chk("wait_fill_cnt", m_cnt, v);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_done", op_done, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_we", tlb_we, 0);
        chk("rst_inv_valid", invtlb_valid, 0);
        chk("rst_rd_tlbidx", rd_tlbidx, 0);
        chk("rst_srch_found", srch_found, 0);

        // TLBWR index 5, ps 12, vppn 0x12345, asid 0x2A, both g=1
        csr_tlbidx  = 32'h0C00_0005;
        csr_tlbehi  = 32'h2468_A000;
        csr_asid    = 32'h0000_002A;
        csr_tlbelo0 = 32'h000A_BC5F;
        csr_tlbelo1 = 32'h0123_4561;
        mem_vppn    = 19'h7_1111;
        mem_asid    = 10'h155;
        issue(3'd2);
        chk("wr_we", tlb_we, 1);
        chk("wr_ready_low", op_ready, 0);
        chk("wr_index", w_index, 5);
        chk("wr_e", w_e, 1);
        chk("wr_g", w_g, 1);
        chk("wr_ps", w_ps, 12);
        chk("wr_vppn", w_vppn, 32'h12345);
        chk("wr_asid", w_asid, 32'h2A);
        chk("wr_ppn0", w_ppn0, 32'hABC);
        chk("wr_ppn1", w_ppn1, 32'h12345);
        chk("wr_mat1", w_mat1, 2);
        chk("wr_stall", mem_stall, 0);
        to_done();

        // TLBRD index 5 returns the written entry
        issue(3'd1);
        chk("rd_r_index", r_index, 5);
        chk("rd_s1_passthru", s1_vppn, 32'h7_1111);
        chk("rd_stall", mem_stall, 0);
        to_done();
        chk("rd5_tlbidx", rd_tlbidx, 32'h0C00_0005);
        chk("rd5_tlbehi", rd_tlbehi, 32'h2468_A000);
        chk("rd5_elo0", rd_tlbelo0, 32'h000A_BC5F);
        chk("rd5_elo1", rd_tlbelo1, 32'h0123_4561);
        chk("rd5_asid", rd_asid, 32'h2A);

        // Rewrite entry 5 with elo1 g=0 so asid matters
        csr_tlbelo1 = 32'h0123_4521;
        issue(3'd2);
        chk("wr2_g_and", w_g, 0);
        to_done();

        // TLBSRCH hit
        mem_va_bit12 = 1'b1;
        issue(3'd0);
        chk("srch_stall", mem_stall, 1);
        chk("srch_s1_vppn", s1_vppn, 32'h12345);
        chk("srch_s1_asid", s1_asid, 32'h2A);
        chk("srch_s1_bit12", s1_va_bit12, 0);
        to_done();
        chk("srch_found", srch_found, 1);
        chk("srch_index", srch_index, 5);

        // TLBSRCH miss on asid
        csr_asid = 32'h0000_002B;
        issue(3'd0);
        chk("srch2_s1_asid", s1_asid, 32'h2B);
        to_done();
        chk("srch2_found", srch_found, 0);

        // TLBRD of empty index 9
        csr_tlbidx = 32'h0000_0009;
        issue(3'd1);
        to_done();
        chk("rd9_tlbidx", rd_tlbidx, 32'h8000_0009);
        chk("rd9_tlbehi", rd_tlbehi, 0);
        chk("rd9_elo0", rd_tlbelo0, 0);
        chk("rd9_elo1", rd_tlbelo1, 0);
        chk("rd9_asid", rd_asid, 0);

        // INVTLB op 5; inv_* changed after accept must not leak through
        inv_op   = 5'd5;
        inv_asid = 10'h2A;
        inv_vppn = 19'h1_2345;
        issue(3'd4);
        inv_op   = 5'd0;
        inv_asid = 10'h3FF;
        inv_vppn = 19'h0;
        #1;
        chk("inv_valid", invtlb_valid, 1);
        chk("inv_op", invtlb_op, 5);
        chk("inv_stall", mem_stall, 1);
        chk("inv_s1_vppn", s1_vppn, 32'h12345);
        chk("inv_s1_asid", s1_asid, 32'h2A);
        to_done();
        chk("inv_valid_done", invtlb_valid, 0);
        chk("inv_err_ok", inv_err, 0);

        // INVTLB op 9 -> error, no invalidate
        inv_op = 5'd9;
        issue(3'd4);
        chk("inv9_valid", invtlb_valid, 0);
        chk("inv9_stall", mem_stall, 1);
        to_done();
        chk("inv9_err", inv_err, 1);

        // op_code 6 goes straight to DONE
        issue(3'd6);
        chk("nop_done", op_done, 1);
        chk("nop_stall", mem_stall, 0);
        chk("nop_we", tlb_we, 0);
        @(negedge clk);
        chk("nop_ready", op_ready, 1);

        // TLBFILL with fill_cnt = 15, then with fill_cnt = 0
        csr_tlbidx = 32'h0000_0003;
        wait_cnt(4'd14);
        issue(3'd3);
        chk("fill15_we", tlb_we, 1);
        chk("fill15_index", w_index, 15);
        to_done();
        wait_cnt(4'd15);
        issue(3'd3);
        chk("fill0_index", w_index, 0);
        to_done();

        // Reset asserted during WRITE
        issue(3'd2);
        chk("pre_rst_we", tlb_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_we", tlb_we, 0);
        chk("rst_mid_ready", op_ready, 1);
        chk("rst_mid_inv_err", inv_err, 0);
        chk("rst_mid_rd_tlbidx", rd_tlbidx, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", op_ready, 1);
        chk("post_rst_done", op_done, 0);
        chk("post_rst_stall", mem_stall, 0);
        // Counter restarted at 0 on release; one edge has passed.
        op_valid = 1'b1;
        op_code  = 3'd3;
        @(negedge clk);
        op_valid = 1'b0;
        chk("post_rst_fill_index", w_index, 1);
        to_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
